cl_dram_matrix_wb: RTL and testbench
====================================

Name: cl_dram_matrix_wb

Overview:
- Write-back stage directly downstream of the matrix dot-product engine.
- Accepts the stream of 64-bit signed dot-product results and packs 8 consecutive results into one 512-bit line.
- Writes each line to DDR through the AXI write channels (AW/W/B) at consecutive 64-byte addresses from a programmed destination base.
- Reports done and error status back to the cfg register block.

Parameters:
ADDR_W, 64, AXI address width
ID_W, 16, AXI ID width
MAX_OUTST, 4, maximum lines issued without a B response (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, begins a job
dst_base  in  ADDR_W  destination byte address; bits [5:0] ignored (treated as 0)
num_results  in  16  number of 64-bit results in the job
res_valid  in  1  result available
res_data  in  64  dot-product result
res_ready  out  1  result accepted when res_valid & res_ready
awvalid/awready  out/in  1  AW handshake
awaddr  out  ADDR_W  line address
awid  out  ID_W  always 0
awlen  out  8  always 0
awsize  out  3  always 3'b110 (64 B)
wvalid/wready  out/in  1  W handshake
wdata  out  512  packed line; result k of the line occupies bits [64k+63:64k]
wstrb  out  64  byte enables
wlast  out  1  always 1
bvalid  in  1  B response valid
bready  out  1  always 1 after reset
bresp  in  2  B response code
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
err  out  1  sticky: a non-OKAY bresp was received in the current job

Behaviour:
- Reset values: all valid outputs 0, res_ready 0, busy 0, done 0, err 0, awaddr 0, wdata 0, wstrb 0, pack/line/outstanding counters 0, state IDLE.
- IDLE:
  - start latches the base (low 6 bits zeroed) and the count, clears err, sets busy, goes to PACK.
  - If num_results==0, skip PACK and go to DRAIN (done fires next cycle, no AXI traffic).
- PACK:
  - res_ready=1.
  - Each accepted result is written to lane pack_cnt (0..7); pack_cnt and the consumed count increment.
  - The line is complete when pack_cnt reaches 8 or the consumed count reaches num_results; go to ISSUE on the next cycle.
- ISSUE:
  - res_ready=0. If outstanding==MAX_OUTST, hold with valids low.
  - Otherwise assert awvalid and wvalid together, 1 cycle after the completing result is accepted.
  - awaddr = base + 64*line_idx.
  - wstrb has 8 ones per filled lane, low lanes first: full line = all ones; a partial line of n results = (1<<8n)-1.
  - awvalid and wvalid each drop independently on their own handshake. The state advances only when both handshakes have completed; AW and W completing in the same cycle is legal.
  - On completion: line_idx++, outstanding++, pack_cnt=0. Go to PACK if results remain, else DRAIN.
- B channel:
  - Every bvalid decrements outstanding. If bvalid and an issue completion land in the same cycle, outstanding is unchanged.
  - bresp!=0 sets err. Responses are never back-pressured.
- DRAIN: wait for outstanding==0, then pulse done for 1 cycle, drop busy, go to IDLE.
- start while busy is ignored.
- Results presented outside a job are not accepted (res_ready=0).
- Reset mid-operation: everything returns to reset values immediately; in-flight AXI handshakes are abandoned.
- Address arithmetic is modulo 2^ADDR_W; no 4 KB boundary handling is needed because every line is 64 B aligned.

Decomposition:
- Package cl_dram_matrix_pkg holds:
  - LINE_BYTES=64, RES_PER_LINE=8, AXI_SIZE_64B=3'b110, AXI_RESP_OKAY=2'b00
  - wb_state_t enum {IDLE, PACK, ISSUE, DRAIN}
  - function lane_strb(n) returning the 64-bit strobe for n filled lanes.
- Sub-module cl_dram_matrix_wb_outst: saturating up/down counter with full/empty flags, used for the outstanding-line tracking.

Test Plan:
- base=0x1000, 16 results 1..16, AXI always ready -> 2 lines: awaddr 0x1000 then 0x1040, wstrb all ones, first line's lane0=1 and lane7=8; after both B responses, done pulse; err=0.
- base=0x2007, 3 results -> one line at awaddr 0x2000, wstrb 0x0000_0000_00FF_FFFF, upper lanes of wdata 0; done after its B response.
- 8 results, wready immediate but awready held low 5 cycles -> wvalid drops after 1 cycle, awvalid held 6 cycles, res_ready stays 0 until AW completes.
- MAX_OUTST=4, 48 results, bvalid withheld -> exactly 4 AW handshakes, then awvalid stays low; releasing one B lets the 5th line issue; done only after all 6 B responses.
- num_results=0 -> done pulses 2 cycles after start, no awvalid; bresp=2'b10 on one line of a 16-result job -> err=1 at done; the next start clears err.
- Reset asserted while awvalid is high in ISSUE -> the next cycle shows all outputs at reset values; a new 8-result job then completes normally.

Source files
------------

// File: rtl/cl_dram_matrix_pkg.sv
// +----------------------------------------------------------------------------+
// | cl_dram_matrix_pkg : shared types, constants and strobe helper for the     |
// |                      matrix result write-back stage.     Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

package cl_dram_matrix_pkg;

  localparam int         LINE_BYTES    = 64;
  localparam int         RES_PER_LINE  = 8;
  localparam logic [2:0] AXI_SIZE_64B  = 3'b110;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } wb_state_t;

  // One 0xFF byte-enable group per filled lane, lowest lanes first.
  function automatic logic [63:0] lane_strb(input logic [3:0] n);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < RES_PER_LINE; i++) begin
      if (4'(i) < n) s[8*i +: 8] = 8'hFF;
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cl_dram_matrix_wb_outst.sv
// +----------------------------------------------------------------------------+
// | cl_dram_matrix_wb_outst : saturating up/down counter tracking lines that   |
// |                           still await a B response.      Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module cl_dram_matrix_wb_outst #(
  parameter int MAX   = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != CNT_W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign full  = (cnt_q == CNT_W'(MAX));
  assign empty = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/cl_dram_matrix_wb.sv
// +----------------------------------------------------------------------------+
// | cl_dram_matrix_wb : packs 64-bit dot-product results into 512-bit lines    |
// |                     and writes them to DDR over AXI AW/W/B.  Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module cl_dram_matrix_wb
  import cl_dram_matrix_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [15:0]       num_results,
  input  logic              res_valid,
  input  logic [63:0]       res_data,
  output logic              res_ready,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [ID_W-1:0]   awid,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic              wvalid,
  input  logic              wready,
  output logic [511:0]      wdata,
  output logic [63:0]       wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              busy,
  output logic              done,
  output logic              err
);

  wb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       num_q, num_d;
  logic [15:0]       consumed_q, consumed_d;
  logic [15:0]       line_idx_q, line_idx_d;
  logic [3:0]        pack_cnt_q, pack_cnt_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [511:0]      wdata_q, wdata_d;
  logic [63:0]       wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              sent_q, sent_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              bready_q, bready_d;

  logic w_aw_hs, w_w_hs, w_aw_seen, w_w_seen;
  logic w_line_done, w_b_dec, w_launch;
  logic w_outst_full, w_outst_empty;

  assign w_aw_hs     = awvalid_q & awready;
  assign w_w_hs      = wvalid_q & wready;
  assign w_aw_seen   = aw_done_q | w_aw_hs;
  assign w_w_seen    = w_done_q | w_w_hs;
  assign w_line_done = (state_q == ISSUE) && sent_q && w_aw_seen && w_w_seen;
  assign w_b_dec     = bvalid & bready_q;

  cl_dram_matrix_wb_outst #(
    .MAX   (MAX_OUTST),
    .CNT_W (4)
  ) u_outst (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_line_done),
    .dec   (w_b_dec),
    .full  (w_outst_full),
    .empty (w_outst_empty)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    consumed_d = consumed_q;
    line_idx_d = line_idx_q;
    pack_cnt_d = pack_cnt_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q & ~awready;
    wvalid_d   = wvalid_q & ~wready;
    aw_done_d  = w_aw_seen;
    w_done_d   = w_w_seen;
    sent_d     = sent_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    bready_d   = 1'b1;
    w_launch   = 1'b0;

    if (w_b_dec && (bresp != AXI_RESP_OKAY)) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = dst_base & ~ADDR_W'(LINE_BYTES - 1);
          num_d      = num_results;
          consumed_d = '0;
          line_idx_d = '0;
          pack_cnt_d = '0;
          wdata_d    = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = (num_results == '0) ? DRAIN : PACK;
        end
      end
      PACK: begin
        if (res_valid) begin
          wdata_d[64*pack_cnt_q[2:0] +: 64] = res_data;
          pack_cnt_d = pack_cnt_q + 4'd1;
          consumed_d = consumed_q + 16'd1;
          if ((pack_cnt_d == 4'(RES_PER_LINE)) || (consumed_d == num_q)) begin
            state_d  = ISSUE;
            w_launch = !w_outst_full;
          end
        end
      end
      ISSUE: begin
        if (!sent_q) begin
          w_launch = !w_outst_full;
        end else if (w_aw_seen && w_w_seen) begin
          line_idx_d = line_idx_q + 16'd1;
          pack_cnt_d = '0;
          wdata_d    = '0;
          sent_d     = 1'b0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = (consumed_q == num_q) ? DRAIN : PACK;
        end
      end
      DRAIN: begin
        if (w_outst_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // AW and W are raised together; each then drops on its own handshake.
    if (w_launch) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      sent_d    = 1'b1;
      awaddr_d  = base_q + ADDR_W'({line_idx_q, 6'b0});
      wstrb_d   = lane_strb(pack_cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      consumed_q <= '0;
      line_idx_q <= '0;
      pack_cnt_q <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      sent_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      consumed_q <= consumed_d;
      line_idx_q <= line_idx_d;
      pack_cnt_q <= pack_cnt_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      sent_q     <= sent_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      bready_q   <= bready_d;
    end
  end

  assign res_ready = (state_q == PACK);
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign awid      = '0;
  assign awlen     = 8'd0;
  assign awsize    = AXI_SIZE_64B;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wlast     = 1'b1;
  assign bready    = bready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cl_dram_matrix_wb.sv
// +----------------------------------------------------------------------------+
// | tb_cl_dram_matrix_wb : scoreboard bench for the result write-back stage.   |
// |                                                          Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cl_dram_matrix_wb;

  localparam int ADDR_W    = 64;
  localparam int ID_W      = 16;
  localparam int MAX_OUTST = 4;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  strb;
  } wline_t;

  typedef struct packed {
    int lines;
    int lat;
  } job_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic [15:0]       num_results = '0;
  logic              res_valid = 1'b0;
  logic [63:0]       res_data = '0;
  logic              res_ready;
  logic              awvalid;
  logic              awready = 1'b0;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic              wvalid;
  logic              wready = 1'b0;
  logic [511:0]      wdata;
  logic [63:0]       wstrb;
  logic              wlast;
  logic              bvalid = 1'b0;
  logic              bready;
  logic [1:0]        bresp = 2'b00;
  logic              busy;
  logic              done;
  logic              err;

  cl_dram_matrix_wb #(
    .ADDR_W    (ADDR_W),
    .ID_W      (ID_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dst_base    (dst_base),
    .num_results (num_results),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .awid        (awid),
    .awlen       (awlen),
    .awsize      (awsize),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wlast       (wlast),
    .bvalid      (bvalid),
    .bready      (bready),
    .bresp       (bresp),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  logic [63:0] exp_aw_q[$];
  wline_t      exp_w_q[$];
  job_t        exp_job_q[$];
  logic [63:0] feed_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int start_cyc = 0;
  int job_aw = 0, job_w = 0, job_b = 0;
  logic err_exp = 1'b0;

  // Environment knobs
  int aw_prob = 100, w_prob = 100, val_prob = 100, b_prob = 100, err_prob = 0;
  int b_budget = -1;
  int aw_fixed = 0, aw_delay = 0, aw_wait = 0;
  int err_once = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Result source
  initial forever begin
    @(negedge clk);
    if (rst_n && feed_q.size() != 0 && $urandom_range(99) < val_prob) begin
      res_valid = 1'b1;
      res_data  = feed_q[0];
    end else begin
      res_valid = 1'b0;
      res_data  = {$urandom, $urandom};
    end
    #1;
    if (res_valid && res_ready) void'(feed_q.pop_front());
  end

  // AXI slave: AW/W readiness and B responses
  initial forever begin
    int pend;
    @(negedge clk);
    if (aw_fixed != 0) begin
      awready = awvalid && (aw_wait >= aw_delay);
      aw_wait = awvalid ? aw_wait + 1 : 0;
    end else begin
      awready = ($urandom_range(99) < aw_prob);
    end
    wready = ($urandom_range(99) < w_prob);
    pend = ((job_aw < job_w) ? job_aw : job_w) - job_b;
    if (rst_n && pend > 0 && b_budget != 0 && $urandom_range(99) < b_prob) begin
      bvalid = 1'b1;
      if (err_once != 0) begin
        bresp = 2'b10;
        err_once = 0;
      end else begin
        bresp = ($urandom_range(99) < err_prob) ? 2'b10 : 2'b00;
      end
      if (b_budget > 0) b_budget--;
    end else begin
      bvalid = 1'b0;
      bresp  = 2'b00;
    end
  end

  // Monitor: samples between edges, pops expectations on each handshake
  initial begin
    int   aw_run = 0, w_run = 0;
    logic aw_prev = 1'b0, w_prev = 1'b0, busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (busy && !busy_prev) begin
          chk("err_cleared_on_start", err, 0);
          job_aw = 0; job_w = 0; job_b = 0; err_exp = 1'b0;
        end
        if (res_valid && !busy) chk("res_ready_outside_job", res_ready, 0);
        if (awvalid || wvalid) chk("res_ready_during_issue", res_ready, 0);
        if ((awvalid || wvalid) && !aw_prev && !w_prev)
          chk("aw_w_raised_together", {awvalid, wvalid}, 2'b11);
        if (bvalid) chk("bready_high", bready, 1);
        if (awvalid && awready) begin
          if (exp_aw_q.size() == 0) chk("unexpected_aw", 1, 0);
          else chk("awaddr", awaddr, exp_aw_q.pop_front());
          chk("aw_fixed_fields", {awid, awlen, awsize}, {16'h0, 8'h0, 3'b110});
          chk("outstanding_limit", ((job_aw - job_b) < MAX_OUTST), 1);
          if (aw_fixed != 0) chk("awvalid_cycles", aw_run + 1, aw_delay + 1);
          job_aw++;
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() == 0) chk("unexpected_w", 1, 0);
          else begin
            wline_t e;
            e = exp_w_q.pop_front();
            chk("wdata", wdata, e.data);
            chk("wstrb", wstrb, e.strb);
          end
          chk("wlast", wlast, 1);
          if (w_prob == 100) chk("wvalid_cycles", w_run + 1, 1);
          job_w++;
        end
        if (bvalid && bready) begin
          job_b++;
          if (bresp != 2'b00) err_exp = 1'b1;
        end
        if (done) begin
          if (exp_job_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            job_t j;
            j = exp_job_q.pop_front();
            chk("lines_aw", job_aw, j.lines);
            chk("lines_w", job_w, j.lines);
            chk("b_before_done", job_b, j.lines);
            chk("err_at_done", err, err_exp);
            chk("busy_low_at_done", busy, 0);
            chk("aw_queue_drained", exp_aw_q.size(), 0);
            if (j.lat >= 0) chk("done_latency", cyc - start_cyc, j.lat);
          end
        end
        aw_run = (awvalid && !awready) ? aw_run + 1 : 0;
        w_run  = (wvalid && !wready) ? w_run + 1 : 0;
      end
      aw_prev   = awvalid;
      w_prev    = wvalid;
      busy_prev = busy;
    end
  end

  // Reference model: line l holds results 8l..8l+7 at (base & ~63) + 64*l.
  task automatic run_job(input logic [63:0] base, input int n, input bit seq);
    logic [63:0] res[$];
    int nl;
    job_t j;
    for (int i = 0; i < n; i++) res.push_back(seq ? 64'(i + 1) : {$urandom, $urandom});
    nl = (n + 7) / 8;
    for (int l = 0; l < nl; l++) begin
      wline_t w;
      w.data = '0;
      w.strb = '0;
      for (int k = 0; k < 8; k++) begin
        if (l * 8 + k < n) begin
          w.data[64*k +: 64] = res[l*8+k];
          w.strb[8*k +: 8]   = 8'hFF;
        end
      end
      exp_aw_q.push_back((base & ~64'h3F) + 64'(l) * 64);
      exp_w_q.push_back(w);
    end
    j.lines = nl;
    j.lat   = (n == 0) ? 2 : -1;
    exp_job_q.push_back(j);
    foreach (res[i]) feed_q.push_back(res[i]);
    @(negedge clk);
    dst_base    = base;
    num_results = 16'(n);
    start       = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_job_q.size() != 0) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) begin
      chk("job_timeout", 1, 0);
      summary();
      $finish;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {awvalid, wvalid, res_ready, busy, done, err, bready}, 0);
    chk("reset_awaddr", awaddr, 0);
    chk("reset_wdata", wdata, 0);
    chk("reset_wstrb", wstrb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);
    chk("bready_after_reset", bready, 1);

    // Two full lines of 1..16
    run_job(64'h1000, 16, 1'b1);
    wait_idle();
    chk("err_clean_job", err, 0);

    // Misaligned base, partial line
    run_job(64'h2007, 3, 1'b0);
    wait_idle();

    // AW held off for 5 cycles, W immediate
    aw_fixed = 1; aw_delay = 5; aw_wait = 0;
    run_job(64'h3000, 8, 1'b0);
    wait_idle();
    aw_fixed = 0;

    // B withheld: issue must stall at MAX_OUTST lines
    b_budget = 0;
    run_job(64'h4000, 48, 1'b0);
    wait_cycles(150);
    chk("aw_count_stalled", job_aw, MAX_OUTST);
    chk("awvalid_low_stalled", awvalid, 0);
    b_budget = 1;
    wait_cycles(40);
    chk("aw_count_after_one_b", job_aw, MAX_OUTST + 1);
    b_budget = -1;
    wait_idle();

    // Empty job, then an error response, then a clean job clearing err
    run_job(64'h5000, 0, 1'b0);
    wait_idle();
    err_once = 1;
    run_job(64'h6000, 16, 1'b0);
    wait_idle();
    chk("err_sticky_after_job", err, 1);
    run_job(64'h7000, 5, 1'b0);
    wait_idle();

    // Randomised jobs, including address wrap and ignored start while busy
    for (int r = 0; r < 14; r++) begin
      logic [63:0] base;
      int n;
      base     = (r % 4 == 3) ? {32'hFFFF_FFFF, 16'hFFFF, 16'($urandom)} : {$urandom, $urandom};
      n        = $urandom_range(0, 40);
      aw_prob  = $urandom_range(30, 100);
      w_prob   = $urandom_range(30, 100);
      val_prob = $urandom_range(30, 100);
      b_prob   = $urandom_range(20, 100);
      err_prob = (r % 3 == 0) ? 25 : 0;
      run_job(base, n, 1'b0);
      if (r % 2 == 1) begin
        wait_cycles(3);
        if (busy) begin
          dst_base    = {$urandom, $urandom};
          num_results = 16'd7;
          start       = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      wait_idle();
    end
    aw_prob = 100; w_prob = 100; val_prob = 100; b_prob = 100; err_prob = 0;

    // Reset while a line is being offered on AW
    aw_fixed = 1; aw_delay = 50; aw_wait = 0;
    run_job(64'h8000, 8, 1'b0);
    begin
      int t;
      t = 0;
      while (!awvalid && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) chk("awvalid_before_reset", awvalid, 1);
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_job_q.delete();
    feed_q.delete();
    job_aw = 0; job_w = 0; job_b = 0; err_exp = 1'b0;
    aw_fixed = 0;
    @(posedge clk);
    #1;
    chk("midreset_flags", {awvalid, wvalid, res_ready, busy, done, err, bready}, 0);
    chk("midreset_awaddr", awaddr, 0);
    chk("midreset_wdata", wdata, 0);
    chk("midreset_wstrb", wstrb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);
    run_job(64'h9040, 8, 1'b0);
    wait_idle();

    wait_cycles(5);
    summary();
    $finish;
  end

endmodule

`default_nettype wire
